mem_ctrl: RTL and testbench

- Data-memory access stage directly downstream of the execute stage.
- Consumes the execute stage's load/store requests: read enable, write enable, address, write data and byte count.
- Runs one transaction at a time on a valid/ready request bus with a separate response channel.
- Stalls the pipeline while a transaction is in flight, then returns a one-cycle valid pulse and byte-lane-aligned read data to execute.

---
 rtl/mem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl -- data-memory access stage sitting directly after execute.
//
// Takes one load or store from execute at a time. It issues the access on a
// valid/ready request bus and, for loads, waits for the matching word on the
// response channel. While the access is in flight it stalls the pipeline. When
// the access finishes it returns a one-cycle completion pulse with byte-lane
// aligned load data.
//
// Optional build macro: MEM_CTRL_TIMEOUT_EN
//   defined   -> a bus watchdog aborts a transaction after TIMEOUT_CYCLES
//                cycles in a bus state. The transaction then completes with
//                err=1 and rdata=0.
//   undefined -> no watchdog; the block waits indefinitely for ready/response.
//
// Parameters:
//   TIMEOUT_CYCLES  bus wait limit in cycles (1..65535); used only with the
//                   watchdog build
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   mem_ctrl_read_en_in    load request from execute
//   mem_ctrl_write_en_in   store request from execute (a load wins if both)
//   mem_ctrl_addr_in       byte address
//   mem_ctrl_wdata_in      store data, bytes packed at the LSB
//   mem_ctrl_byte_num_in   store byte mask, LSB packed (0001/0011/1111)
//   mem_ctrl_valid_out     one-cycle transaction-complete pulse (registered)
//   mem_ctrl_rdata_out     load data, addressed byte at [7:0] (registered)
//   mem_ctrl_hold_out      pipeline stall request (combinational)
//   mem_ctrl_err_out       error pulse, coincident with valid (registered)
//   bus_req_valid_out      request valid (registered)
//   bus_req_ready_in       request accepted
//   bus_req_we_out         1 = write (registered)
//   bus_req_addr_out       word address, [1:0] = 00 (registered)
//   bus_req_wdata_out      lane-shifted write data (registered)
//   bus_req_wstrb_out      lane-shifted byte strobes (registered)
//   bus_resp_valid_in      read response valid
//   bus_resp_data_in       read response word
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ctrl_read_en_in,
  input  logic        mem_ctrl_write_en_in,
  input  logic [31:0] mem_ctrl_addr_in,
  input  logic [31:0] mem_ctrl_wdata_in,
  input  logic [3:0]  mem_ctrl_byte_num_in,
  output logic        mem_ctrl_valid_out,
  output logic [31:0] mem_ctrl_rdata_out,
  output logic        mem_ctrl_hold_out,
  output logic        mem_ctrl_err_out,
  output logic        bus_req_valid_out,
  input  logic        bus_req_ready_in,
  output logic        bus_req_we_out,
  output logic [31:0] bus_req_addr_out,
  output logic [31:0] bus_req_wdata_out,
  output logic [3:0]  bus_req_wstrb_out,
  input  logic        bus_resp_valid_in,
  input  logic [31:0] bus_resp_data_in
);

  // Reject an out-of-range wait limit at elaboration time.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_ctrl: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Transaction context, captured while idle.
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  byte_num_reg;

  // The context as seen this cycle. In IDLE the request fields for the
  // first bus cycle must come straight from execute, because the context
  // registers load on the same edge.
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_byte_num;
  logic [1:0]  cur_off;
  logic [7:0]  strb_wide;
  logic        store_misaligned;

  logic [31:0] rd_aligned;
  logic        timeout_hit;
  logic        abort_err;

  logic        valid_next;
  logic        err_next;
  logic [31:0] rdata_next;
  logic        req_valid_next;
  logic        req_we_next;
  logic [31:0] req_addr_next;
  logic [31:0] req_wdata_next;
  logic [3:0]  req_wstrb_next;

  always_comb begin
    if (state_reg == IDLE) begin
      cur_addr     = mem_ctrl_addr_in;
      cur_wdata    = mem_ctrl_wdata_in;
      cur_byte_num = mem_ctrl_byte_num_in;
    end else begin
      cur_addr     = addr_reg;
      cur_wdata    = wdata_reg;
      cur_byte_num = byte_num_reg;
    end
  end

  assign cur_off = cur_addr[1:0];

  // Shift the mask in 8 bits so that lanes pushed past byte 3 remain
  // visible for the misalignment test.
  assign strb_wide        = {4'b0000, cur_byte_num} << cur_off;
  assign store_misaligned = (|strb_wide[7:4]) || (cur_byte_num == 4'b0000);

  // Load alignment: output lane gi takes response byte gi+offset, and is
  // zero-filled once that index runs off the top of the word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
    logic [2:0] src_idx;
    assign src_idx = 3'(gi) + {1'b0, addr_reg[1:0]};
    assign rd_aligned[8*gi +: 8] =
      src_idx[2] ? 8'h00 : bus_resp_data_in[8*src_idx[1:0] +: 8];
  end

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_reg;
  logic        bus_busy;

  assign bus_busy = (state_reg == RD_REQ) || (state_reg == RD_WAIT) ||
                    (state_reg == WR_REQ);

  // Held at zero while idle, so the count is 0 in the first bus cycle. It
  // then runs through RD_REQ and RD_WAIT as one continuous budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_reg <= 16'd0;
    end else if (bus_busy) begin
      tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
    end else begin
      tmo_cnt_reg <= 16'd0;
    end
  end

  assign timeout_hit = bus_busy && (tmo_cnt_reg == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register and context capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg     <= 32'd0;
      wdata_reg    <= 32'd0;
      byte_num_reg <= 4'd0;
    end else if (state_reg == IDLE) begin
      addr_reg     <= mem_ctrl_addr_in;
      wdata_reg    <= mem_ctrl_wdata_in;
      byte_num_reg <= mem_ctrl_byte_num_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. abort_err marks a completion that ends in error: a
  // misaligned store, or a watchdog abort. Genuine completion (write accepted,
  // read response) wins over a watchdog expiry in the same cycle. A read that
  // is accepted on the expiry cycle is still aborted, and its response is
  // then ignored because the FSM has left RD_WAIT.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    abort_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_ctrl_read_en_in) begin
          state_next = RD_REQ;
        end else if (mem_ctrl_write_en_in) begin
          if (store_misaligned) begin
            state_next = DONE;
            abort_err  = 1'b1;
          end else begin
            state_next = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (timeout_hit) begin
          state_next = DONE;
          abort_err  = 1'b1;
        end else if (bus_req_ready_in) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus_resp_valid_in) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = DONE;
          abort_err  = 1'b1;
        end
      end
      WR_REQ: begin
        if (bus_req_ready_in) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = DONE;
          abort_err  = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic. Every output except hold is registered, so the values here
  // are what the outputs must show in the state being entered. Request fields
  // are zero whenever no request is being presented.
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_next     = (state_next == DONE);
    err_next       = abort_err;
    rdata_next     = 32'd0;
    req_valid_next = (state_next == RD_REQ) || (state_next == WR_REQ);
    req_we_next    = (state_next == WR_REQ);
    req_addr_next  = 32'd0;
    req_wdata_next = 32'd0;
    req_wstrb_next = 4'd0;

    if ((state_reg == RD_WAIT) && (state_next == DONE) && !abort_err) begin
      rdata_next = rd_aligned;
    end

    if (req_valid_next) begin
      req_addr_next = {cur_addr[31:2], 2'b00};
    end

    if (req_we_next) begin
      req_wdata_next = cur_wdata << {cur_off, 3'b000};
      req_wstrb_next = strb_wide[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ctrl_valid_out <= 1'b0;
      mem_ctrl_err_out   <= 1'b0;
      mem_ctrl_rdata_out <= 32'd0;
      bus_req_valid_out  <= 1'b0;
      bus_req_we_out     <= 1'b0;
      bus_req_addr_out   <= 32'd0;
      bus_req_wdata_out  <= 32'd0;
      bus_req_wstrb_out  <= 4'd0;
    end else begin
      mem_ctrl_valid_out <= valid_next;
      mem_ctrl_err_out   <= err_next;
      mem_ctrl_rdata_out <= rdata_next;
      bus_req_valid_out  <= req_valid_next;
      bus_req_we_out     <= req_we_next;
      bus_req_addr_out   <= req_addr_next;
      bus_req_wdata_out  <= req_wdata_next;
      bus_req_wstrb_out  <= req_wstrb_next;
    end
  end

  // The stall is dropped in DONE so that execute advances in the valid cycle.
  // It is raised as soon as a request appears while idle.
  assign mem_ctrl_hold_out =
    ((state_reg == IDLE) && (mem_ctrl_read_en_in || mem_ctrl_write_en_in)) ||
    (state_reg == RD_REQ) || (state_reg == RD_WAIT) || (state_reg == WR_REQ);

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl -- directed, self-checking bench for mem_ctrl.
// Covers reset state, aligned and sub-word loads at every offset, load
// priority over store, stores with immediate and delayed ready, misaligned
// stores, reset in the middle of a transaction, and the watchdog (or its
// absence, depending on the build).
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        read_en;
  logic        write_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_num;
  logic        valid;
  logic [31:0] rdata;
  logic        hold;
  logic        err;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_data;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_ctrl_read_en_in  (read_en),
    .mem_ctrl_write_en_in (write_en),
    .mem_ctrl_addr_in     (addr),
    .mem_ctrl_wdata_in    (wdata),
    .mem_ctrl_byte_num_in (byte_num),
    .mem_ctrl_valid_out   (valid),
    .mem_ctrl_rdata_out   (rdata),
    .mem_ctrl_hold_out    (hold),
    .mem_ctrl_err_out     (err),
    .bus_req_valid_out    (req_valid),
    .bus_req_ready_in     (req_ready),
    .bus_req_we_out       (req_we),
    .bus_req_addr_out     (req_addr),
    .bus_req_wdata_out    (req_wdata),
    .bus_req_wstrb_out    (req_wstrb),
    .bus_resp_valid_in    (resp_valid),
    .bus_resp_data_in     (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, " valid"},     32'(valid),     32'd0);
    check_vec({tag, " err"},       32'(err),       32'd0);
    check_vec({tag, " rdata"},     rdata,          32'd0);
    check_vec({tag, " req_valid"}, 32'(req_valid), 32'd0);
    check_vec({tag, " req_we"},    32'(req_we),    32'd0);
    check_vec({tag, " req_addr"},  req_addr,       32'd0);
    check_vec({tag, " req_wdata"}, req_wdata,      32'd0);
    check_vec({tag, " req_wstrb"}, 32'(req_wstrb), 32'd0);
    check_vec({tag, " hold"},      32'(hold),      32'd0);
  endtask

  // Load with immediate ready and a response one cycle after acceptance.
  task automatic rd_txn(input string tag, input logic [31:0] a,
                        input logic [31:0] word, input logic [31:0] exp_addr,
                        input logic [31:0] exp_rdata, input logic also_write);
    read_en   = 1'b1;
    write_en  = also_write;
    byte_num  = 4'b1111;
    wdata     = 32'h5555_5555;
    addr      = a;
    req_ready = 1'b1;
    #1;
    check_vec({tag, " hold c0"}, 32'(hold), 32'd1);
    tick();
    read_en  = 1'b0;
    write_en = 1'b0;
    check_vec({tag, " req_valid"}, 32'(req_valid), 32'd1);
    check_vec({tag, " req_we"},    32'(req_we),    32'd0);
    check_vec({tag, " req_addr"},  req_addr,       exp_addr);
    check_vec({tag, " req_wstrb"}, 32'(req_wstrb), 32'd0);
    check_vec({tag, " hold c1"},   32'(hold),      32'd1);
    tick();
    check_vec({tag, " req_drop"}, 32'(req_valid), 32'd0);
    check_vec({tag, " hold c2"},  32'(hold),      32'd1);
    check_vec({tag, " early"},    32'(valid),     32'd0);
    resp_valid = 1'b1;
    resp_data  = word;
    tick();
    resp_valid = 1'b0;
    resp_data  = 32'd0;
    req_ready  = 1'b0;
    check_vec({tag, " valid"},   32'(valid), 32'd1);
    check_vec({tag, " rdata"},   rdata,      exp_rdata);
    check_vec({tag, " err"},     32'(err),   32'd0);
    check_vec({tag, " hold c3"}, 32'(hold),  32'd0);
    tick();
    check_vec({tag, " pulse"}, 32'(valid), 32'd0);
  endtask

  // Store with immediate ready.
  task automatic wr_txn(input string tag, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] bn,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                        input logic [3:0] exp_wstrb);
    write_en  = 1'b1;
    addr      = a;
    wdata     = d;
    byte_num  = bn;
    req_ready = 1'b1;
    tick();
    write_en = 1'b0;
    check_vec({tag, " req_valid"}, 32'(req_valid), 32'd1);
    check_vec({tag, " req_we"},    32'(req_we),    32'd1);
    check_vec({tag, " req_addr"},  req_addr,       exp_addr);
    check_vec({tag, " req_wdata"}, req_wdata,      exp_wdata);
    check_vec({tag, " req_wstrb"}, 32'(req_wstrb), 32'(exp_wstrb));
    tick();
    req_ready = 1'b0;
    check_vec({tag, " valid"},     32'(valid),     32'd1);
    check_vec({tag, " err"},       32'(err),       32'd0);
    check_vec({tag, " rdata"},     rdata,          32'd0);
    check_vec({tag, " req_drop"},  32'(req_valid), 32'd0);
    check_vec({tag, " hold"},      32'(hold),      32'd0);
    tick();
    check_vec({tag, " pulse"}, 32'(valid), 32'd0);
  endtask

  // Store that must never reach the bus.
  task automatic bad_store(input string tag, input logic [31:0] a,
                           input logic [3:0] bn);
    write_en  = 1'b1;
    addr      = a;
    wdata     = 32'hFFFF_FFFF;
    byte_num  = bn;
    req_ready = 1'b1;
    tick();
    write_en  = 1'b0;
    req_ready = 1'b0;
    check_vec({tag, " valid"},     32'(valid),     32'd1);
    check_vec({tag, " err"},       32'(err),       32'd1);
    check_vec({tag, " rdata"},     rdata,          32'd0);
    check_vec({tag, " req_valid"}, 32'(req_valid), 32'd0);
    tick();
    check_vec({tag, " pulse"},     32'(valid),     32'd0);
    check_vec({tag, " err_pulse"}, 32'(err),       32'd0);
    check_vec({tag, " no_req"},    32'(req_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst        = 1'b1;
    read_en    = 1'b0;
    write_en   = 1'b0;
    addr       = 32'd0;
    wdata      = 32'd0;
    byte_num   = 4'd0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = 32'd0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Loads: aligned word, then each sub-word offset.
    rd_txn("lw_0x100", 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    rd_txn("lb_0x203", 32'h0000_0203, 32'h1122_3344, 32'h0000_0200, 32'h0000_0011, 1'b0);
    rd_txn("ld_0x301", 32'h0000_0301, 32'hA1B2_C3D4, 32'h0000_0300, 32'h00A1_B2C3, 1'b0);
    rd_txn("ld_0x402", 32'h0000_0402, 32'hCAFE_F00D, 32'h0000_0400, 32'h0000_CAFE, 1'b0);
    rd_txn("rd_prio",  32'h0000_0500, 32'h0BAD_F00D, 32'h0000_0500, 32'h0BAD_F00D, 1'b1);

    // Stores with immediate ready.
    wr_txn("sw_0x600", 32'h0000_0600, 32'h1234_5678, 4'b1111,
           32'h0000_0600, 32'h1234_5678, 4'b1111);
    wr_txn("sb_0x007", 32'h0000_0007, 32'h0000_005A, 4'b0001,
           32'h0000_0004, 32'h5A00_0000, 4'b1000);

    // SH at offset 2 with ready held low for 4 cycles.
    write_en  = 1'b1;
    addr      = 32'h0000_0102;
    wdata     = 32'h0000_ABCD;
    byte_num  = 4'b0011;
    req_ready = 1'b0;
    tick();
    write_en = 1'b0;
    addr     = 32'hFFFF_FFFF;
    wdata    = 32'hFFFF_FFFF;
    byte_num = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      check_vec("sh_wait req_valid", 32'(req_valid), 32'd1);
      check_vec("sh_wait req_we",    32'(req_we),    32'd1);
      check_vec("sh_wait req_addr",  req_addr,       32'h0000_0100);
      check_vec("sh_wait req_wdata", req_wdata,      32'hABCD_0000);
      check_vec("sh_wait req_wstrb", 32'(req_wstrb), 32'b1100);
      check_vec("sh_wait valid",     32'(valid),     32'd0);
      tick();
    end
    req_ready = 1'b1;
    check_vec("sh_rdy req_wdata", req_wdata, 32'hABCD_0000);
    tick();
    req_ready = 1'b0;
    check_vec("sh valid",    32'(valid),     32'd1);
    check_vec("sh err",      32'(err),       32'd0);
    check_vec("sh req_drop", 32'(req_valid), 32'd0);
    check_vec("sh hold",     32'(hold),      32'd0);
    tick();
    check_vec("sh pulse", 32'(valid), 32'd0);

    // Misaligned stores.
    bad_store("sw_0x101",  32'h0000_0101, 4'b1111);
    bad_store("sh_0x103",  32'h0000_0103, 4'b0011);
    bad_store("bn0_0x100", 32'h0000_0100, 4'b0000);

    // Reset while a store waits for ready: request fields must clear.
    write_en  = 1'b1;
    addr      = 32'h0000_0A01;
    wdata     = 32'h0000_0077;
    byte_num  = 4'b0001;
    req_ready = 1'b0;
    tick();
    write_en = 1'b0;
    check_vec("wr_pre_rst req_wstrb", 32'(req_wstrb), 32'b0010);
    rst = 1'b1;
    tick();
    check_all_zero("rst_wr");
    rst = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check_vec("rst_wr no_valid", 32'(valid), 32'd0);

    // Reset while waiting for a read response; a late response is ignored.
    read_en   = 1'b1;
    addr      = 32'h0000_0C00;
    req_ready = 1'b1;
    tick();
    read_en = 1'b0;
    tick();
    req_ready = 1'b0;
    check_vec("rd_pre_rst hold", 32'(hold), 32'd1);
    rst = 1'b1;
    tick();
    check_all_zero("rst_rd");
    rst        = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'hFFFF_FFFF;
    tick();
    resp_valid = 1'b0;
    check_vec("rst_rd no_valid", 32'(valid), 32'd0);
    check_vec("rst_rd rdata",    rdata,      32'd0);
    tick();
    check_vec("rst_rd still_idle", 32'(valid), 32'd0);
    check_vec("rst_rd hold",       32'(hold),  32'd0);

    // Read with ready held low.
    read_en   = 1'b1;
    addr      = 32'h0000_0800;
    req_ready = 1'b0;
    tick();
    read_en = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      check_vec("tmo req_valid", 32'(req_valid), 32'd1);
      check_vec("tmo valid",     32'(valid),     32'd0);
      tick();
    end
    check_vec("tmo done valid", 32'(valid),     32'd1);
    check_vec("tmo done err",   32'(err),       32'd1);
    check_vec("tmo done rdata", rdata,          32'd0);
    check_vec("tmo req_drop",   32'(req_valid), 32'd0);
    check_vec("tmo hold",       32'(hold),      32'd0);
    tick();
    resp_valid = 1'b1;
    resp_data  = 32'h1234_5678;
    check_vec("tmo pulse", 32'(valid), 32'd0);
    tick();
    resp_valid = 1'b0;
    check_vec("tmo late_resp valid", 32'(valid), 32'd0);
    check_vec("tmo late_resp rdata", rdata,      32'd0);
`else
    for (int k = 1; k <= 12; k++) begin
      check_vec("nowd req_valid", 32'(req_valid), 32'd1);
      check_vec("nowd valid",     32'(valid),     32'd0);
      check_vec("nowd hold",      32'(hold),      32'd1);
      tick();
    end
    req_ready = 1'b1;
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    resp_data  = 32'h8765_4321;
    tick();
    resp_valid = 1'b0;
    check_vec("nowd valid_end", 32'(valid), 32'd1);
    check_vec("nowd rdata",     rdata,      32'h8765_4321);
    check_vec("nowd err",       32'(err),   32'd0);
    tick();
`endif

    // A normal load still works after all of the above.
    rd_txn("lw_final", 32'h0000_0F02, 32'h0102_0304, 32'h0000_0F00, 32'h0000_0102, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
